// File: rtl/seg_run_ctrl_if.sv
// Handshake bundle between the board-input side and the runner controller.
// master drives start/btn; slave (the controller) drives the display and game status.
interface seg_run_ctrl_if;
    logic       start;
    logic       btn;
    logic [7:0] posOut;
    logic [7:0] score;
    logic [2:0] level;
    logic [1:0] lives;
    logic       hitFlash;
    logic       missFlash;
    logic       gameOver;

    modport master (
        output start, btn,
        input  posOut, score, level, lives, hitFlash, missFlash, gameOver
    );

    modport slave (
        input  start, btn,
        output posOut, score, level, lives, hitFlash, missFlash, gameOver
    );
endinterface

// File: rtl/seg_run_ctrl.sv
// Runner game controller: steps a one-hot position at a level-dependent rate,
// scores button presses against a target and tracks level, lives and game over.
module seg_run_ctrl #(
    parameter int unsigned TICK_DIV    = 4,
    parameter logic [7:0]  TARGET      = 8'b00010000,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned SHOW_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst,
    seg_run_ctrl_if.slave bus
);

    localparam int unsigned MAXC = (8 * TICK_DIV > SHOW_CYCLES) ? 8 * TICK_DIV : SHOW_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RUN, HIT, MISS, OVER} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    pos, pos_n;
    logic [7:0]    score, score_n;
    logic [2:0]    level, level_n;
    logic [1:0]    lives, lives_n;
    logic          btn_prev;
    logic          press;
    int unsigned   period;
    logic [CW-1:0] step_last;

    always_comb begin
        period    = TICK_DIV * (32'd8 - 32'(level));
        step_last = CW'(period - 32'd1);
        press     = bus.btn & ~btn_prev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pos      <= 8'h80;
            score    <= '0;
            level    <= '0;
            lives    <= 2'(LIVES);
            btn_prev <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pos      <= pos_n;
            score    <= score_n;
            level    <= level_n;
            lives    <= lives_n;
            btn_prev <= bus.btn;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pos_n   = pos;
        score_n = score;
        level_n = level;
        lives_n = lives;
        case (state)
            IDLE, OVER: begin
                if (bus.start) begin
                    score_n = '0;
                    level_n = '0;
                    lives_n = 2'(LIVES);
                    cnt_n   = '0;
                    pos_n   = 8'h80;
                    state_n = RUN;
                end
            end
            RUN: begin
                // A press wins over a step in the same cycle and judges the pre-shift position.
                if (press) begin
                    cnt_n = '0;
                    if (pos == TARGET) begin
                        score_n = (score == 8'hFF) ? score : score + 8'd1;
                        level_n = (level == 3'd7) ? level : level + 3'd1;
                        state_n = HIT;
                    end else begin
                        lives_n = lives - 2'd1;
                        state_n = MISS;
                    end
                end else if (cnt == step_last) begin
                    pos_n = {pos[0], pos[7:1]};
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HIT: begin
                if (cnt == SHOW_LAST) begin
                    pos_n   = 8'h80;
                    cnt_n   = '0;
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            MISS: begin
                if (cnt == SHOW_LAST) begin
                    cnt_n = '0;
                    if (lives == 2'd0) begin
                        state_n = OVER;
                    end else begin
                        pos_n   = 8'h80;
                        state_n = RUN;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.posOut    = pos;
    assign bus.score     = score;
    assign bus.level     = level;
    assign bus.lives     = lives;
    assign bus.hitFlash  = (state == HIT);
    assign bus.missFlash = (state == MISS);
    assign bus.gameOver  = (state == OVER);

endmodule
